reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 11 +
 rtl/reg_file_sb_popcount.sv | 19 +
 rtl/reg_file_sb.sv | 109 ++++++++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared processor constants for the scoreboarded register file.
//   DefDataW : default register width in bits
//   DefAddrW : default address width (register count = 2**DefAddrW)
//   RegZero  : index of the hard-wired zero register
package reg_file_sb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned RegZero  = 0;

endpackage

// File: rtl/reg_file_sb_popcount.sv
// Population count of a bit vector.
//   bits_i  : vector to count
//   count_o : number of set bits in bits_i
module reg_file_sb_popcount #(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 6
) (
  input  logic [Width-1:0] bits_i,
  output logic [CntW-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      count_o = count_o + CntW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending (scoreboard) bit.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   readReg1/2            : read addresses
//   readData1/2           : combinational read data, bypassed from a same-cycle writeback
//   busy1/2               : combinational pending flag of the read addresses
//   regWrite/writeReg/writeData : writeback port, clears the pending bit
//   rsvEn/rsvReg          : reservation port, sets the pending bit
//   pendCount             : registered number of pending registers
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              busy1,
  output logic              busy2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              rsvEn,
  input  logic [ADDR_W-1:0] rsvReg,
  output logic [ADDR_W:0]   pendCount
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam int unsigned CntW    = ADDR_W + 1;

  logic [DATA_W-1:0]  mem_q [NumRegs];
  logic [NumRegs-1:0] pending_q, pending_d;
  logic [CntW-1:0]    pend_count_q, pend_count_d;

  logic wr_en, rsv_en;
  logic wr_hit1, wr_hit2, rsv_hit1, rsv_hit2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return ZERO_R0 && (addr == ADDR_W'(RegZero));
  endfunction

  // Requests are dropped entirely while reset is held, including the read bypass.
  assign wr_en  = reset && regWrite && !is_zero(writeReg);
  assign rsv_en = reset && rsvEn && !is_zero(rsvReg);

  assign wr_hit1  = wr_en && (writeReg == readReg1);
  assign wr_hit2  = wr_en && (writeReg == readReg2);
  assign rsv_hit1 = rsv_en && (rsvReg == readReg1);
  assign rsv_hit2 = rsv_en && (rsvReg == readReg2);

  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (!is_zero(readReg1)) begin
      readData1 = wr_hit1 ? writeData : mem_q[readReg1];
    end
    if (!is_zero(readReg2)) begin
      readData2 = wr_hit2 ? writeData : mem_q[readReg2];
    end
  end

  // A writeback this cycle hides busy unless the same register is re-reserved too.
  always_comb begin
    busy1 = !is_zero(readReg1) && pending_q[readReg1] && !(wr_hit1 && !rsv_hit1);
    busy2 = !is_zero(readReg2) && pending_q[readReg2] && !(wr_hit2 && !rsv_hit2);
  end

  // Reservation is applied after the clear so a colliding new producer wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[writeReg] = 1'b0;
    end
    if (rsv_en) begin
      pending_d[rsvReg] = 1'b1;
    end
  end

  reg_file_sb_popcount #(
    .Width (NumRegs),
    .CntW  (CntW)
  ) u_popcount (
    .bits_i  (pending_d),
    .count_o (pend_count_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
      pending_q    <= '0;
      pend_count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[writeReg] <= writeData;
      end
      pending_q    <= pending_d;
      pend_count_q <= pend_count_d;
    end
  end

  assign pendCount = pend_count_q;

endmodule
